key_dir_pulser: RTL

- Turns four raw keyboard direction levels into clean, mutually exclusive, single-cycle direction pulses.
- Those pulses (up, down, right, left) feed the frog movement logic and the keystroke-driven pseudo-random generator.
- Provides synchronization, debounce, fixed priority resolution, and optional auto-repeat while a key is held.
- Sits between the keyboard scan-code decoder and all game-logic consumers of direction strobes.

---
 rtl/key_dir_pulser.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_dir_pulser.sv
// Debounced, priority-resolved, optionally auto-repeating direction strobes
// derived from four raw keyboard levels.
module key_dir_pulser #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_right,
  input  logic       key_left,
  output logic       up,
  output logic       down,
  output logic       right,
  output logic       left,
  output logic       dir_valid,
  output logic [1:0] dir_code
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic             REP_ON   = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_REPEAT   = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Pulse vector order is {right, left, up, down}.
  function automatic logic [3:0] dir_onehot(input logic [1:0] code);
    logic [3:0] vec;
    case (code)
      DIR_RIGHT: vec = 4'b1000;
      DIR_LEFT:  vec = 4'b0100;
      DIR_UP:    vec = 4'b0010;
      DIR_DOWN:  vec = 4'b0001;
      default:   vec = 4'b0000;
    endcase
    return vec;
  endfunction

  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic             cand_valid_s;
  logic [1:0]       cand_code_s;
  logic             same_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [1:0]       dir_r;
  logic [1:0]       dir_nx_s;
  logic             fire_s;
  logic [3:0]       pulse_nx_s;
  logic             valid_nx_s;
  logic [3:0]       pulse_r;
  logic             valid_r;

  assign raw_s = {key_right, key_left, key_up, key_down};

  // Two-flop synchronizer for the asynchronous key levels.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Fixed priority right > left > up > down, matching the consumer decode.
  always_comb begin
    cand_valid_s = 1'b1;
    cand_code_s  = DIR_RIGHT;
    if (sync2_r[3]) begin
      cand_code_s = DIR_RIGHT;
    end else if (sync2_r[2]) begin
      cand_code_s = DIR_LEFT;
    end else if (sync2_r[1]) begin
      cand_code_s = DIR_UP;
    end else if (sync2_r[0]) begin
      cand_code_s = DIR_DOWN;
    end else begin
      cand_valid_s = 1'b0;
      cand_code_s  = DIR_RIGHT;
    end
  end

  assign same_s = cand_valid_s && (cand_code_s == dir_r);

  // State, counter and latched direction registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= DIR_RIGHT;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      dir_r   <= dir_nx_s;
    end
  end

  // Next-state logic; the counter restarts on every state entry.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    dir_nx_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = CNT_ZERO;
        if (cand_valid_s) begin
          state_nx_s = ST_DEBOUNCE;
          dir_nx_s   = cand_code_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (!same_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_nx_s = ST_HOLD;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!same_s) begin
          state_nx_s = ST_RELEASE;
          cnt_nx_s   = CNT_ZERO;
        end else if (REP_ON && (cnt_r == DLY_LAST)) begin
          state_nx_s = ST_REPEAT;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      ST_REPEAT: begin
        if (!same_s) begin
          state_nx_s = ST_RELEASE;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == PER_LAST) begin
          cnt_nx_s = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        // Any key activity restarts the release debounce.
        if (cand_valid_s) begin
          cnt_nx_s = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: a pulse is requested on each terminal-count cycle.
  always_comb begin
    fire_s = 1'b0;
    case (state_r)
      ST_DEBOUNCE: fire_s = same_s && (cnt_r == DEB_LAST);
      ST_HOLD:     fire_s = same_s && REP_ON && (cnt_r == DLY_LAST);
      ST_REPEAT:   fire_s = same_s && (cnt_r == PER_LAST);
      default:     fire_s = 1'b0;
    endcase
    if (fire_s) begin
      pulse_nx_s = dir_onehot(dir_r);
    end else begin
      pulse_nx_s = 4'b0000;
    end
    valid_nx_s = (state_nx_s == ST_HOLD) || (state_nx_s == ST_REPEAT);
  end

  // Registered pulse and valid outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pulse_r <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      pulse_r <= pulse_nx_s;
      valid_r <= valid_nx_s;
    end
  end

  assign right     = pulse_r[3];
  assign left      = pulse_r[2];
  assign up        = pulse_r[1];
  assign down      = pulse_r[0];
  assign dir_valid = valid_r;
  assign dir_code  = dir_r;

endmodule
